// File: rtl/iter_divider.sv
// -----------------------------------------------------------------------------
// iter_divider
//   Multi-cycle radix-2 restoring divider, the responder side of the ALU
//   start/ready divide handshake. The requester holds `start` high until it
//   sees `ready`, then latches Hi/Lo from `result`. One quotient bit is
//   produced per clock, so a divide takes WIDTH iterations. A zero divisor
//   is detected at capture and skips the iteration loop.
//
// Parameters
//   WIDTH       operand width; iteration count equals WIDTH
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   signed_div  1 = signed divide (DIV), 0 = unsigned (DIVU); sampled at capture
//   opdata1     dividend
//   opdata2     divisor
//   start       request, held high until `ready` has been seen
//   annul       flush: abort any divide in progress and clear `result`
//   result      {remainder, quotient}: Hi = [2W-1:W], Lo = [W-1:0]
//   ready       `result` is valid for the current request
//
// States
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for start; operands captured on start & ~annul
//   DIVZERO | divisor was zero; result loads 0 on the way to END
//   ON      | one restoring iteration per cycle, counter 0 .. WIDTH-1
//   END     | result valid; ready asserted until start falls or annul
// -----------------------------------------------------------------------------
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div,
  input  logic [WIDTH-1:0]     opdata1,
  input  logic [WIDTH-1:0]     opdata2,
  input  logic                 start,
  input  logic                 annul,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_a_q, neg_a_d;   // dividend was negative (signed mode only)
  logic               neg_b_q, neg_b_d;   // divisor was negative (signed mode only)
  logic [WIDTH-1:0]   dvs_q, dvs_d;       // divisor magnitude
  logic [WIDTH-1:0]   rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0]   dvd_q, dvd_d;       // dividend bits shifting out, quotient bits shifting in
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  // Iteration datapath
  logic [WIDTH:0]     shifted;
  logic               fits;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quo_fix;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Shift {rem, dvd} left by one and trial-subtract the divisor from the top
  // WIDTH+1 bits. Because rem < divisor, a successful subtraction always
  // leaves a value below 2^WIDTH, so the modular WIDTH-bit difference is exact.
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    fits     = (shifted >= {1'b0, dvs_q});
    diff     = shifted[WIDTH-1:0] - dvs_q;
    rem_next = fits ? diff : shifted[WIDTH-1:0];
    quo_next = {dvd_q[WIDTH-2:0], fits};
    // Quotient negative when operand signs differ; remainder follows the
    // dividend. Negating 2^(W-1) wraps to itself, giving the -2^(W-1)/-1 result.
    quo_fix  = (neg_a_q ^ neg_b_q) ? (~quo_next + 1'b1) : quo_next;
    rem_fix  = neg_a_q ? (~rem_next + 1'b1) : rem_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start && !annul) begin
          neg_a_d = signed_div & opdata1[WIDTH-1];
          neg_b_d = signed_div & opdata2[WIDTH-1];
          dvd_d   = magnitude(opdata1, signed_div & opdata1[WIDTH-1]);
          dvs_d   = magnitude(opdata2, signed_div & opdata2[WIDTH-1]);
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (opdata2 == '0) ? DIVZERO : ON;
        end
      end

      DIVZERO: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          result_d = '0;
          state_d  = END;
        end
      end

      ON: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_next;
          dvd_d = quo_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            result_d = {rem_fix, quo_fix};
            state_d  = END;
          end
        end
      end

      END: begin
        if (!start) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush wins over everything, including a concurrent start.
    if (annul) begin
      state_d  = IDLE;
      result_d = '0;
    end
  end

  // ready lags END entry by one cycle and drops on the edge that sees start
  // fall or annul rise.
  assign ready_d = (state_q == END) && start && !annul;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dvs_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle radix-2 restoring divider.
- Responder end of the ALU start/ready divide handshake.
- Execute stage holds `start` high and stalls until `ready`, then latches Hi/Lo from `result`.
- Supports signed (DIV) and unsigned (DIVU) operation, plus a flush/annul input.

Parameters:
- WIDTH, 32, operand width. `result` is 2*WIDTH bits. Iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low.
- signed_div  input  1  1 = signed divide, 0 = unsigned. Sampled with operands.
- opdata1  input  WIDTH  dividend (rs).
- opdata2  input  WIDTH  divisor (rt).
- start  input  1  request; held high by the requester until it has seen `ready`.
- annul  input  1  flush: abort any divide in progress.
- result  output  2*WIDTH  {remainder, quotient}: Hi = [2W-1:W], Lo = [W-1:0].
- ready  output  1  `result` is valid for the current request.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on `rst`.
- While `rst` is low:
  - state = IDLE, counter = 0, `result` = 0, `ready` = 0.
  - Reset mid-divide discards all work; no partial result is visible.
- States: IDLE, DIVZERO, ON, END. State is registered; `ready` is a registered output.
- IDLE:
  - If `start` & ~`annul`: capture `signed_div`, the operand signs and the operand magnitudes.
  - In signed mode, a negative operand is two's-complement negated; otherwise it is used raw.
  - Next state: DIVZERO if `opdata2` == 0, else ON with counter = 0.
  - Otherwise stay in IDLE with `ready` = 0.
- DIVZERO: load `result` = 0, then go to END.
- ON:
  - One iteration per cycle.
  - Shift the {partial remainder, dividend} register left by 1.
  - Trial-subtract the divisor from the upper WIDTH+1 bits.
  - If the difference is non-negative, keep it and set the quotient LSB to 1; else restore and set the LSB to 0.
  - The counter increments each cycle.
  - After the iteration with counter == WIDTH-1, go to END and load `result`.
- Sign fix-up on the END-entry load (signed mode only):
  - Quotient is negated if the captured signs differ.
  - Remainder takes the sign of the dividend.
- END:
  - `ready` = 1 and `result` holds.
  - When `start` falls or `annul` = 1: go to IDLE with `ready` = 0.
  - `result` keeps its value until the next capture, reset, or annul.
- Latency:
  - Normal divide: `ready` first high WIDTH+1 cycles after the edge that captured `start` (33 for WIDTH=32).
  - Divide by zero: `ready` first high 2 cycles after capture.
- Abort rules:
  - `annul` = 1 in any state: next state IDLE, `ready` = 0, `result` = 0. `annul` has priority over `start`.
  - `start` falling while in ON or DIVZERO: abort to IDLE with `ready` = 0; `result` unchanged.
- Operands are internal copies. Changes on `opdata1`, `opdata2` or `signed_div` after capture are ignored.
- Overflow case, signed -2^(W-1) / -1: quotient = 0x80000000 (wrap), remainder = 0. No exception is raised.
- Back-to-back requests:
  - After END returns to IDLE, a new `start` is accepted on the following edge.
  - A requester that keeps `start` high continuously re-triggers only after the END→IDLE transition. In practice, `start` drops when `ready` is seen.
- Unsigned results must equal opdata1/opdata2 and opdata1%opdata2.
- Signed results must equal the truncating (toward-zero) quotient and remainder.

Test Plan:
- Unsigned 100/7:
  - Stimulus: `signed_div` = 0, `start` held high.
  - Required: `ready` rises exactly 33 cycles after capture, `result` = {0x00000002, 0x0000000E}.
  - Then drop `start`: `ready` falls the next cycle.
- Signed sign combinations:
  - -7/2 → {0xFFFFFFFF, 0xFFFFFFFD}.
  - 7/-2 → {0x00000001, 0xFFFFFFFD}.
  - -7/-2 → {0xFFFFFFFF, 0x00000003}.
  - The same bit patterns divided unsigned, 0xFFFFFFF9/2 → {0x00000001, 0x7FFFFFFC}.
- Divide by zero: 5/0 → `ready` high 2 cycles after capture, `result` = 0. Signed 0x80000000/0xFFFFFFFF → {0x00000000, 0x80000000}.
- Annul at cycle 10 of ON → IDLE next cycle, `ready` = 0 throughout, `result` = 0. A fresh 9/3 afterwards → {0, 3} at cycle 33.
- Reset mid-ON:
  - Pull `rst` low asynchronously between edges at iteration 20: `result` = 0 and `ready` = 0 immediately.
  - After release, the first divide completes normally.
- Randomized signed and unsigned operands, checked against a reference model, with 1000 back-to-back requests: no lost or duplicated `ready` and no operand bleed-through.
